// File: rtl/alu16_accum_if.sv
// alu16_accum_if: operand/opcode bus into the ALU and its decoded select and registered results
interface alu16_accum_if #(parameter int WIDTH = 16);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0] opcode;
    logic [11:0] select;
    logic [WIDTH-1:0] result;
    logic carry;
    logic overflow;
    modport master (output a, b, opcode, input select, result, carry, overflow);
    modport slave (input a, b, opcode, output select, result, carry, overflow);
endinterface

// File: rtl/alu16_accum.sv
// alu16_accum: one-hot decoded 16-bit ALU with registered result, carry and overflow
module alu16_accum #(parameter int WIDTH = 16) (
    input logic clk,
    input logic rst,
    alu16_accum_if.slave bus
);
    logic [11:0] sel;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0] sum;
    logic arith;
    logic [WIDTH-1:0] result_d, result_q;
    logic carry_d, carry_q, overflow_d, overflow_q;
    always_comb begin
        sel = 12'h800;
        case (bus.opcode)
            4'b0000: sel = 12'h001;
            4'b0001: sel = 12'h002;
            4'b0010: sel = 12'h004;
            4'b0011: sel = 12'h008;
            4'b0100: sel = 12'h010;
            4'b0101: sel = 12'h020;
            4'b0110: sel = 12'h040;
            4'b1000: sel = 12'h080;
            4'b1001: sel = 12'h100;
            4'b1010: sel = 12'h200;
            4'b1011: sel = 12'h400;
            default: sel = 12'h800;
        endcase
    end
    // SUB reuses the adder as a + ~b + 1, with sel[8] as the carry-in
    always_comb begin
        arith = sel[7] | sel[8];
        b_eff = sel[8] ? ~bus.b : bus.b;
        sum = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sel[8]};
        result_d = ({WIDTH{sel[0]}} & (bus.a & bus.b))
                 | ({WIDTH{sel[1]}} & (bus.a | bus.b))
                 | ({WIDTH{sel[2]}} & ~bus.a)
                 | ({WIDTH{sel[3]}} & (bus.a ^ bus.b))
                 | ({WIDTH{sel[4]}} & ~(bus.a & bus.b))
                 | ({WIDTH{sel[5]}} & ~(bus.a | bus.b))
                 | ({WIDTH{sel[6]}} & ~(bus.a ^ bus.b))
                 | ({WIDTH{arith}} & sum[WIDTH-1:0])
                 | ({WIDTH{sel[9]}} & {1'b0, bus.a[WIDTH-1:1]})
                 | ({WIDTH{sel[10]}} & {bus.a[WIDTH-2:0], 1'b0});
        carry_d = arith & sum[WIDTH];
        overflow_d = arith & (bus.a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != bus.a[WIDTH-1]);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            carry_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            result_q <= result_d;
            carry_q <= carry_d;
            overflow_q <= overflow_d;
        end
    end
    assign bus.select = sel;
    assign bus.result = result_q;
    assign bus.carry = carry_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_alu16_accum.sv
// tb_alu16_accum: directed vector table, corner sequences and randomized reference-model check
module tb_alu16_accum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int compared = 0;
    int mismatched = 0;
    alu16_accum_if bus ();
    alu16_accum dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic rst;
        logic [3:0] op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic c;
        logic v;
        string name;
    } vec_t;
    vec_t tv[$];
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask
    task automatic step(input logic r, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        rst = r;
        bus.opcode = op;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        #1;
    endtask
    task automatic expect_out(input string name, input logic [15:0] r, input logic c, input logic v);
        check({name, ".result"}, {16'h0, bus.result}, {16'h0, r});
        check({name, ".carry"}, {31'h0, bus.carry}, {31'h0, c});
        check({name, ".overflow"}, {31'h0, bus.overflow}, {31'h0, v});
    endtask
    // Reference: plain integer arithmetic, returns {carry, overflow, result}
    function automatic logic [17:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int s;
        case (op)
            4'd0: return {2'b00, a & b};
            4'd1: return {2'b00, a | b};
            4'd2: return {2'b00, ~a};
            4'd3: return {2'b00, a ^ b};
            4'd4: return {2'b00, ~(a & b)};
            4'd5: return {2'b00, ~(a | b)};
            4'd6: return {2'b00, ~(a ^ b)};
            4'd8: begin
                s = sa + sb;
                return {ua + ub > 65535, s > 32767 || s < -32768, 16'(ua + ub)};
            end
            4'd9: begin
                s = sa - sb;
                return {ua >= ub, s > 32767 || s < -32768, 16'(ua - ub)};
            end
            4'd10: return {2'b00, 16'(ua / 2)};
            4'd11: return {2'b00, 16'(ua * 2)};
            default: return 18'h0;
        endcase
    endfunction
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        int sel_idx[16] = '{0, 1, 2, 3, 4, 5, 6, 11, 7, 8, 9, 10, 11, 11, 11, 11};
        logic [3:0] undef_ops[5] = '{4'h7, 4'hC, 4'hD, 4'hE, 4'hF};
        logic [17:0] m;
        logic r;
        logic [3:0] op;
        logic [15:0] a, b;
        tv.push_back('{1'b1, 4'h8, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0, "rst_add"});
        tv.push_back('{1'b0, 4'h8, 16'h0005, 16'h0005, 16'h000A, 1'b0, 1'b0, "post_rst_add"});
        tv.push_back('{1'b0, 4'h0, 16'hC001, 16'h8001, 16'h8001, 1'b0, 1'b0, "and"});
        tv.push_back('{1'b0, 4'h1, 16'h0002, 16'h0001, 16'h0003, 1'b0, 1'b0, "or"});
        tv.push_back('{1'b0, 4'h2, 16'h4002, 16'h1234, 16'hBFFD, 1'b0, 1'b0, "not"});
        tv.push_back('{1'b0, 4'h3, 16'h4002, 16'h0003, 16'h4001, 1'b0, 1'b0, "xor"});
        tv.push_back('{1'b0, 4'h4, 16'h0002, 16'h0003, 16'hFFFD, 1'b0, 1'b0, "nand"});
        tv.push_back('{1'b0, 4'h5, 16'h0002, 16'h0003, 16'hFFFC, 1'b0, 1'b0, "nor"});
        tv.push_back('{1'b0, 4'h6, 16'h0002, 16'h0003, 16'hFFFE, 1'b0, 1'b0, "xnor"});
        tv.push_back('{1'b0, 4'h8, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, "add"});
        tv.push_back('{1'b0, 4'h9, 16'h0002, 16'h0003, 16'hFFFF, 1'b0, 1'b0, "sub_neg"});
        tv.push_back('{1'b0, 4'h8, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, "add_ovf"});
        tv.push_back('{1'b0, 4'h9, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, "sub_ovf"});
        tv.push_back('{1'b0, 4'h8, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, "add_wrap"});
        tv.push_back('{1'b0, 4'h9, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, "sub_wrap"});
        tv.push_back('{1'b0, 4'hA, 16'h8001, 16'hFFFF, 16'h4000, 1'b0, 1'b0, "shr"});
        tv.push_back('{1'b0, 4'hB, 16'h8001, 16'hFFFF, 16'h0002, 1'b0, 1'b0, "shl"});
        tv.push_back('{1'b0, 4'hB, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b0, "shl_zero"});
        tv.push_back('{1'b0, 4'hA, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b0, "shr_zero"});
        tv.push_back('{1'b0, 4'h0, 16'hFFFF, 16'h00F0, 16'h00F0, 1'b0, 1'b0, "lat_and"});
        tv.push_back('{1'b0, 4'h8, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, "lat_add"});
        tv.push_back('{1'b0, 4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, "lat_clear"});
        tv.push_back('{1'b0, 4'h0, 16'h1234, 16'hFF00, 16'h1200, 1'b0, 1'b0, "lat_and2"});
        bus.opcode = 4'h0;
        bus.a = 16'h0;
        bus.b = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset_state", 16'h0, 1'b0, 1'b0);
        foreach (tv[i]) begin
            step(tv[i].rst, tv[i].op, tv[i].a, tv[i].b);
            expect_out(tv[i].name, tv[i].r, tv[i].c, tv[i].v);
        end
        for (int o = 0; o < 16; o++) begin
            bus.opcode = 4'(o);
            #1;
            check($sformatf("select_op%0h", o), {20'h0, bus.select}, 32'd1 << sel_idx[o]);
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 4'h1, 16'h00F0, 16'h000F);
            expect_out("pre_clear_or", 16'h00FF, 1'b0, 1'b0);
            step(1'b0, undef_ops[k], 16'hAAAA, 16'h5555);
            expect_out($sformatf("clear_op%0h", undef_ops[k]), 16'h0, 1'b0, 1'b0);
        end
        step(1'b0, 4'h8, 16'hFFFF, 16'h0001);
        expect_out("midrst_pre", 16'h0000, 1'b1, 1'b0);
        step(1'b1, 4'h8, 16'h7FFF, 16'h0001);
        expect_out("midrst_hold", 16'h0000, 1'b0, 1'b0);
        step(1'b0, 4'h8, 16'h0002, 16'h0003);
        expect_out("midrst_after", 16'h0005, 1'b0, 1'b0);
        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 19) == 0);
            op = 4'($urandom_range(0, 15));
            a = 16'($urandom);
            b = 16'($urandom);
            if (n % 7 == 0) a = (n % 2 == 0) ? 16'h7FFF : 16'h8000;
            step(r, op, a, b);
            m = r ? 18'h0 : model(op, a, b);
            expect_out($sformatf("rand%0d_op%0h", n, op), m[15:0], m[17], m[16]);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/alu16_accum.md
# alu16_accum

16-bit single-cycle ALU with a registered result (accumulator) stage, forming the CS4341 ALU datapath. A 4-bit opcode is decoded into a one-hot 12-bit select vector that steers one of twelve combinational function units (logic, add/subtract, shift, clear) into a 16-bit output register. The block sits between the operand/opcode sources and any consumer of the ALU result, with exactly one clock of latency.

## Interface
- WIDTH, 16, operand/result width; all behaviour below is specified for 16.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- a  input  WIDTH  operand A (unsigned/two's-complement)
- b  input  WIDTH  operand B
- opcode  input  4  operation code
- select  output  12  one-hot decode of opcode (combinational)
- result  output  WIDTH  registered ALU result (accumulator)
- carry  output  1  registered adder carry-out
- overflow  output  1  registered signed overflow

## Operation
- Opcode map and select bit: 0000 AND, select[0]; 0001 OR, [1]; 0010 NOT, [2]; 0011 XOR, [3]; 0100 NAND, [4]; 0101 NOR, [5]; 0110 XNOR, [6]; 1000 ADD, [7]; 1001 SUB, [8]; 1010 SHR, [9]; 1011 SHL, [10]; 1111 CLEAR, [11].
- Undefined opcodes (0111, 1100, 1101, 1110) decode to CLEAR (select = bit 11 only).
- select is always exactly one-hot; it depends only on opcode, not on clk/rst.
- Bitwise ops operate on all 16 bits; NOT uses a only, b ignored.
- ADD: a + b mod 2^16; SUB: a + ~b + 1 mod 2^16. select[8] drives the adder's subtract control.
- carry = carry-out of bit 15 of the adder (SUB: 1 = no borrow). overflow = signed overflow: operands' effective sign bits equal and sum sign differs.
- For non-arithmetic ops, carry and overflow register as 0.
- SHR: logical right shift of a by 1, MSB filled with 0. SHL: logical left shift of a by 1, LSB filled with 0. b ignored; shifted-out bit discarded.
- CLEAR: result loads 0.
- Result mux is one-hot, driven by select.

## Timing
- On each rising clk edge: if rst, result=0, carry=0, overflow=0; else result/carry/overflow load the function value computed from current a, b, opcode.
- Latency: 1 cycle from a/b/opcode change to result; throughput one operation per cycle.
- No handshake; inputs sampled every edge. Output holds between edges.
- rst has priority over any opcode; reset mid-stream discards that cycle's operation, next non-reset edge computes normally.
- Reset value of select: not registered, reflects current opcode.
- Wrap-around: ADD 0xFFFF+0x0001 gives 0x0000, carry 1, overflow 0; SUB 0x0000-0x0001 gives 0xFFFF, carry 0.
- Back-to-back opcode changes each produce their own result one cycle later; no accumulation across cycles (result depends only on the preceding edge's inputs).

## Test plan
- Reset: assert rst one edge with opcode=ADD, a=5, b=5 -> result=0x0000, carry=0, overflow=0; deassert -> next edge result=0x000A.
- Logic: AND a=0xC001,b=0x8001 -> 0x8001; OR a=0x0002,b=0x0001 -> 0x0003; NOT a=0x4002 -> 0xBFFD; XOR a=0x4002,b=0x0003 -> 0x4001; NAND a=0x0002,b=0x0003 -> 0xFFFD; NOR same -> 0xFFFC; XNOR same -> 0xFFFE; each one edge later.
- Arithmetic: ADD 0x0002+0x0003 -> 0x0005,c=0,v=0; SUB 0x0002-0x0003 -> 0xFFFF,c=0,v=0; ADD 0x7FFF+0x0001 -> 0x8000,v=1; SUB 0x8000-0x0001 -> 0x7FFF,v=1,c=1; ADD 0xFFFF+0x0001 -> 0x0000,c=1.
- Shift: SHR a=0x8001 -> 0x4000; SHL a=0x8001 -> 0x0002; SHL/SHR a=0x0000 -> 0x0000.
- Decode/CLEAR: sweep all 16 opcodes -> select one-hot per map, 0111/1100-1110/1111 give 0x800 and result 0x0000 after a prior nonzero result.
- Latency: change opcode every cycle (AND, ADD, CLEAR) -> each result appears exactly one edge after its inputs, no carry-over between cycles.
